// File: rtl/rv32i_multicycle.sv
// rtl/rv32i_multicycle.sv - multicycle RV32I subset core with one shared memory port
// Debug register read port, retired-instruction counter, halt on illegal/misaligned/timeout.
module rv32i_multicycle #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          CNT_W       = 32,
    parameter int          MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      pc,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data,
    output logic [CNT_W-1:0] instret,
    output logic             halted
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BEQ, S_JAL, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d, oldpc_q, oldpc_d, instr_q, instr_d, res_q, res_d;
    logic [31:2]       addr_q, addr_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [31:0]       wait_q, wait_d;
    logic [31:0]       regs_q [0:31];
    logic              rf_we;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_j;
    logic [31:0] ea, br_tgt, jal_tgt, alu_b, alu_y;
    logic        is_r, is_i, is_lw, is_sw, is_beq, is_jal, mem_state, timed_out;

    assign opcode  = instr_q[6:0];
    assign rd      = instr_q[11:7];
    assign f3      = instr_q[14:12];
    assign rs1     = instr_q[19:15];
    assign rs2     = instr_q[24:20];
    assign f7      = instr_q[31:25];
    // x0 is never written, so it reads zero without a special case
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    assign is_r   = (opcode == 7'b0110011) &&
                    ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010)) ||
                     (f7 == 7'b0100000 && f3 == 3'b000));
    assign is_i   = (opcode == 7'b0010011) && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010);
    assign is_lw  = (opcode == 7'b0000011) && (f3 == 3'b010);
    assign is_sw  = (opcode == 7'b0100011) && (f3 == 3'b010);
    assign is_beq = (opcode == 7'b1100011) && (f3 == 3'b000);
    assign is_jal = (opcode == 7'b1101111);

    assign ea      = rs1_val + (is_sw ? imm_s : imm_i);
    assign br_tgt  = oldpc_q + imm_b;
    assign jal_tgt = oldpc_q + imm_j;

    always_comb begin
        alu_b = (state_q == S_EXEC_R) ? rs2_val : imm_i;
        alu_y = '0;
        case (f3)
            3'b000:  alu_y = (state_q == S_EXEC_R && f7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b111:  alu_y = rs1_val & alu_b;
            3'b110:  alu_y = rs1_val | alu_b;
            3'b010:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            default: alu_y = '0;
        endcase
    end

    // Request lines come straight from the state so a zero-wait fetch takes one cycle;
    // gating with reset keeps the port idle while reset is held.
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign mem_req   = !reset && mem_state;
    assign mem_we    = !reset && (state_q == S_MEM_WR);
    assign mem_addr  = {(state_q == S_FETCH) ? pc_q[31:2] : addr_q, 2'b00};
    assign mem_wdata = rs2_val;
    assign timed_out = (MEM_TIMEOUT > 0) && !mem_ready && (wait_q == 32'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        oldpc_d   = oldpc_q;
        instr_d   = instr_q;
        res_d     = res_q;
        addr_d    = addr_q;
        instret_d = instret_q;
        rf_we     = 1'b0;
        wait_d    = (mem_state && !mem_ready) ? wait_q + 32'd1 : 32'd0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    oldpc_d = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_r)                 state_d = S_EXEC_R;
                else if (is_i)            state_d = S_EXEC_I;
                else if (is_lw || is_sw)  state_d = S_MEM_ADR;
                else if (is_beq)          state_d = S_BEQ;
                else if (is_jal)          state_d = S_JAL;
                else begin
                    state_d = S_HALT;
                    pc_d    = oldpc_q;
                end
            end
            S_EXEC_R, S_EXEC_I: begin
                res_d   = alu_y;
                state_d = S_ALU_WB;
            end
            S_ALU_WB, S_MEM_WB: begin
                rf_we     = 1'b1;
                instret_d = instret_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_MEM_ADR: begin
                addr_d = ea[31:2];
                if (ea[1:0] != 2'b00) begin
                    state_d = S_HALT;
                    pc_d    = oldpc_q;
                end else begin
                    state_d = is_sw ? S_MEM_WR : S_MEM_RD;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    if (state_q == S_MEM_RD) begin
                        res_d   = mem_rdata;
                        state_d = S_MEM_WB;
                    end else begin
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                end else if (timed_out) begin
                    state_d = S_HALT;
                    pc_d    = oldpc_q;
                end
            end
            S_BEQ: begin
                if (rs1_val == rs2_val && br_tgt[1:0] != 2'b00) begin
                    state_d = S_HALT;
                    pc_d    = oldpc_q;
                end else begin
                    if (rs1_val == rs2_val) pc_d = br_tgt;
                    instret_d = instret_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end
            end
            S_JAL: begin
                if (jal_tgt[1:0] != 2'b00) begin
                    state_d = S_HALT;
                    pc_d    = oldpc_q;
                end else begin
                    res_d   = oldpc_q + 32'd4;
                    pc_d    = jal_tgt;
                    state_d = S_ALU_WB;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            oldpc_q   <= RESET_PC;
            instr_q   <= '0;
            res_q     <= '0;
            addr_q    <= '0;
            instret_q <= '0;
            wait_q    <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            oldpc_q   <= oldpc_d;
            instr_q   <= instr_d;
            res_q     <= res_d;
            addr_q    <= addr_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
            if (rf_we && rd != 5'd0) regs_q[rd] <= res_q;
        end
    end

    assign pc       = pc_q;
    assign dbg_data = regs_q[dbg_addr];
    assign instret  = instret_q;
    assign halted   = (state_q == S_HALT);
endmodule

// File: tb/tb_rv32i_multicycle.sv
// tb/tb_rv32i_multicycle.sv - directed self-checking bench for rv32i_multicycle
module tb_rv32i_multicycle;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready_w, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_data, instret;
    logic [4:0]  dbg_addr = 5'd0;

    logic        reset2 = 1'b1;
    logic        t2_req, t2_we, t2_halted;
    logic [31:0] t2_addr, t2_wdata, t2_pc, t2_dbg_data, t2_instret;
    logic [31:0] t2_rdata = 32'd0;
    logic        t2_ready = 1'b0;
    logic [4:0]  t2_dbg_addr = 5'd0;

    rv32i_multicycle dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready_w), .pc(pc),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .instret(instret), .halted(halted)
    );

    rv32i_multicycle #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset2), .mem_req(t2_req), .mem_we(t2_we), .mem_addr(t2_addr),
        .mem_wdata(t2_wdata), .mem_rdata(t2_rdata), .mem_ready(t2_ready), .pc(t2_pc),
        .dbg_addr(t2_dbg_addr), .dbg_data(t2_dbg_data), .instret(t2_instret), .halted(t2_halted)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    logic        m_ready = 1'b0;
    logic        force_ready = 1'b0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_lat = 0;
    int          cnt = 0;
    logic [31:0] wr_addr = 32'd0, wr_data = 32'd0;
    int          wr_cnt = 0;
    int          stab_err = 0;
    logic        p_req = 1'b0, p_ready = 1'b0, p_we = 1'b0, p_reset = 1'b1;
    logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;

    assign mem_ready_w = m_ready | force_ready;
    initial mem_rdata = 32'd0;

    // Memory model: slow_lat wait cycles for accesses to slow_addr, zero-wait elsewhere.
    always @(negedge clk) begin
        if (p_req && !p_ready && !p_reset && !reset &&
            !(mem_req && mem_addr == p_addr && mem_we == p_we && (!p_we || mem_wdata == p_wdata)))
            stab_err++;
        if (mem_req && mem_addr[1:0] != 2'b00) stab_err++;
        if (m_ready) cnt = 0;
        if (mem_req) begin
            cnt = cnt + 1;
            m_ready = (cnt > ((mem_addr == slow_addr) ? slow_lat : 0));
            mem_rdata = mem[mem_addr[7:2]];
        end else begin
            cnt = 0;
            m_ready = 1'b0;
        end
        if (!reset && mem_req && mem_we && (m_ready || force_ready)) begin
            mem[mem_addr[7:2]] = mem_wdata;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
            wr_cnt++;
        end
        p_req = mem_req; p_ready = m_ready | force_ready; p_we = mem_we;
        p_addr = mem_addr; p_wdata = mem_wdata; p_reset = reset;
    end

    int passed = 0, total = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        wr_cnt = 0;
        wr_addr = 32'd0;
        wr_data = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        force_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [9];

    int c [0:4];

    initial begin
        vecs[0] = '{32'h006283B3, 5'd7,  32'h0000_0004};  // add  x7,x5,x6
        vecs[1] = '{32'h005324B3, 5'd9,  32'h0000_0001};  // slt  x9,x6,x5
        vecs[2] = '{32'h40628533, 5'd10, 32'h0000_000A};  // sub  x10,x5,x6
        vecs[3] = '{32'h0062F5B3, 5'd11, 32'h0000_0005};  // and  x11,x5,x6
        vecs[4] = '{32'h0062E633, 5'd12, 32'hFFFF_FFFF};  // or   x12,x5,x6
        vecs[5] = '{32'hFFE32693, 5'd13, 32'h0000_0001};  // slti x13,x6,-2
        vecs[6] = '{32'h0F037713, 5'd14, 32'h0000_00F0};  // andi x14,x6,0xF0
        vecs[7] = '{32'hFF02E793, 5'd15, 32'hFFFF_FFF7};  // ori  x15,x5,-16
        vecs[8] = '{32'h00500013, 5'd0,  32'h0000_0000};  // addi x0,x0,5

        clear_mem();
        step();
        step();
        check("reset_pc", pc, 32'h0);
        check("reset_instret", instret, 32'h0);
        check("reset_halted", {31'b0, halted}, 32'h0);
        check("reset_mem_req", {31'b0, mem_req}, 32'h0);

        // addi x5,x0,7 / addi x6,x0,-3 / <op>: 12 cycles, 3 retired
        for (int v = 0; v < 9; v++) begin
            clear_mem();
            mem[0] = 32'h00700293;
            mem[1] = 32'hFFD00313;
            mem[2] = vecs[v].instr;
            do_reset();
            repeat (12) step();
            dbg_addr = vecs[v].rd;
            #1;
            check($sformatf("vec%0d_reg", v), dbg_data, vecs[v].exp);
            check($sformatf("vec%0d_pc", v), pc, 32'h0000_000C);
            check($sformatf("vec%0d_instret", v), instret, 32'd3);
        end

        // sw/lw through a 2-wait-cycle data word at 0x08
        clear_mem();
        mem[0]  = 32'h00700293;  // addi x5,x0,7
        mem[1]  = 32'h01C0006F;  // jal x0,+28 -> 0x20
        mem[8]  = 32'h00502423;  // sw x5,8(x0)
        mem[9]  = 32'h00802403;  // lw x8,8(x0)
        slow_addr = 32'h0000_0008;
        slow_lat = 2;
        do_reset();
        c[0] = 0;
        for (int k = 1; k <= 4; k++) begin
            int n = 0;
            while (instret != 32'(k) && n < 60) begin
                step();
                n++;
            end
            c[k] = cyc;
        end
        dbg_addr = 5'd8;
        #1;
        check("lw_x8", dbg_data, 32'd7);
        check("sw_addr", wr_addr, 32'h0000_0008);
        check("sw_data", wr_data, 32'd7);
        check("sw_count", 32'(wr_cnt), 32'd1);
        check("sw_cycles", 32'(c[3] - c[2]), 32'd6);
        check("lw_cycles", 32'(c[4] - c[3]), 32'd7);
        slow_addr = 32'hFFFF_FFFF;
        slow_lat = 0;

        // beq at 0x10, taken (-8) and not taken
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            mem[0] = 32'h00700293;
            mem[1] = 32'h00000013;
            mem[2] = 32'h00000013;
            mem[3] = 32'h00000013;
            mem[4] = (t == 0) ? 32'hFE528CE3 : 32'hFE628CE3;
            do_reset();
            repeat (18) step();
            check($sformatf("beq%0d_instret_c2", t), instret, 32'd4);
            step();
            check($sformatf("beq%0d_instret_c3", t), instret, 32'd5);
            check($sformatf("beq%0d_fetch", t), mem_addr, (t == 0) ? 32'h08 : 32'h14);
            check($sformatf("beq%0d_pc", t), pc, (t == 0) ? 32'h08 : 32'h14);
        end

        // jal x0,+32 then jal x1,+16 at 0x20
        clear_mem();
        mem[0] = 32'h0200006F;
        mem[8] = 32'h010000EF;
        do_reset();
        repeat (8) step();
        dbg_addr = 5'd1;
        #1;
        check("jal_link", dbg_data, 32'h0000_0024);
        check("jal_fetch", mem_addr, 32'h0000_0030);
        check("jal_instret", instret, 32'd2);

        // illegal opcode 0x7F at 0x04
        clear_mem();
        mem[0] = 32'h00000013;
        mem[1] = 32'h0000007F;
        do_reset();
        repeat (5) step();
        check("ill_halted_c5", {31'b0, halted}, 32'h0);
        step();
        check("ill_halted_c6", {31'b0, halted}, 32'h1);
        check("ill_pc", pc, 32'h0000_0004);
        repeat (3) step();
        check("ill_mem_req", {31'b0, mem_req}, 32'h0);
        check("ill_instret", instret, 32'd1);

        // misaligned lw x8,6(x0) halts before a data access
        clear_mem();
        mem[0] = 32'h00602403;
        do_reset();
        repeat (3) step();
        check("mis_halted", {31'b0, halted}, 32'h1);
        check("mis_pc", pc, 32'h0);
        check("mis_mem_req", {31'b0, mem_req}, 32'h0);

        // timeout instance: mem_ready never rises
        step();
        reset2 = 1'b0;
        repeat (3) step();
        check("to_halted_c3", {31'b0, t2_halted}, 32'h0);
        check("to_req_c3", {31'b0, t2_req}, 32'h1);
        step();
        check("to_halted_c4", {31'b0, t2_halted}, 32'h1);
        check("to_req_c4", {31'b0, t2_req}, 32'h0);

        // reset during a MEM_RD wait, with mem_ready pending in the reset cycle
        clear_mem();
        mem[0] = 32'h00000013;
        mem[1] = 32'h00802403;
        mem[2] = 32'h0000_0055;
        slow_addr = 32'h0000_0008;
        slow_lat = 50;
        do_reset();
        repeat (9) step();
        check("rst_in_memrd", mem_addr, 32'h0000_0008);
        reset = 1'b1;
        force_ready = 1'b1;
        step();
        dbg_addr = 5'd8;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_x8", dbg_data, 32'h0);
        force_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_fetch_req", {31'b0, mem_req}, 32'h1);
        check("rst_fetch_addr", mem_addr, 32'h0);

        check("mem_port_stable", 32'(stab_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
